riscv_data_memory: RTL
======================

Name: riscv_data_memory

Overview:
- Data-bus responder for the RISC-V core's load/store port.
- Accepts the core's read/write requests and performs byte-lane writes into a synchronous word RAM.
- Returns load data right-aligned: addressed byte/half at bit 0, upper bits zero; the core does sign/zero extension.
- Inserts programmable wait states via a busy/stall output that drives the core's pipeline jam input.

Parameters:
ADDR_WIDTH, 12, word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words.
BASE_ADDR, 32'h0001_0000, byte address of word 0; must be aligned to 4*2^ADDR_WIDTH.
WAIT_STATES, 0, extra stall cycles per access (0..15).

Ports:
clock  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-low reset.
data_address  input  32  byte address from core.
data_width  input  2  0=byte, 1=half, 2=word, 3=reserved.
data_out  input  32  store data from core.
data_read  input  1  load request.
data_write  input  1  store request.
data_in  output  32  registered load data to core.
busy  output  1  stall request; core holds request stable while high.
misaligned  output  1  one-cycle pulse flagging an illegal alignment (feature-dependent).

Behaviour:
- Reset (reset==0 at rising edge): state IDLE, wait counter 0, data_in=0, busy=0, misaligned=0. RAM contents are preserved. Reset mid-WAIT aborts the access: no write commits, no read data.
- Request present = data_read|data_write.
- Request in range = (data_address - BASE_ADDR) < 4*2^ADDR_WIDTH. Word index = offset[ADDR_WIDTH+1:2].
- FSM states: IDLE, WAIT.
- WAIT_STATES==0:
  - Request in cycle T commits at the edge ending T.
  - Load data drives data_in from T+1.
  - busy is always 0.
- WAIT_STATES=W>0:
  - Request in IDLE at cycle T: busy=1 combinationally in T; go to WAIT with counter=W-1.
  - In WAIT, busy=1 while counter!=0; counter decrements each cycle.
  - The cycle with counter==0 in WAIT (cycle T+W): busy=0, the access commits at its closing edge, and state returns to IDLE.
  - Load data is valid from T+W+1.
  - Initiator must hold address/width/data/strobes stable T..T+W. If the request drops in WAIT, return to IDLE with no commit.
- data_in holds its value until the next load commits. Stores and idle cycles do not change it.
- Store lanes:
  - byte: data_out[7:0] goes to lane addr[1:0].
  - half: data_out[15:0] goes to lanes {addr[1],0}/{addr[1],1}.
  - word: all four lanes.
  - Other lanes are unchanged.
- Load alignment:
  - byte: data_in = {24'b0, lane addr[1:0]}.
  - half: data_in = {16'b0, half addr[1]}.
  - word: data_in = full word.
- Out of range: stores are ignored; loads return 32'h0. Wait states still apply.
- data_read and data_write both high: treated as store only; data_in is unchanged.
- Back-to-back requests: with W==0 a new request is accepted every cycle. With W>0 the next request is accepted in the cycle after commit (IDLE).

Optional Feature:
Macro RISCV_DMEM_MISALIGN_EN.
- Defined:
  - Illegal alignment at commit (half with addr[0]=1, word with addr[1:0]!=0, or width==3) suppresses the store.
  - A load in that case returns 32'h0.
  - misaligned pulses high for exactly the cycle after commit.
- Undefined:
  - misaligned is tied to 0.
  - Offending low address bits are ignored: half uses addr[1] only, word ignores addr[1:0], width 3 is treated as word.

Test Plan:
- Reset: reset=0 for 2 cycles then 1 -> data_in=0, busy=0, misaligned=0.
- W=0: sw 32'hDEADBEEF @BASE+8, next cycle lw @BASE+8 -> data_in=32'hDEADBEEF one cycle after the load.
- Byte lanes: sb 8'h5A @BASE+9 over word 32'h11223344 -> word 32'h11225A44; lbu @BASE+9 -> 32'h0000005A; lh @BASE+10 -> 32'h00001122.
- W=3: lw @BASE+0 held stable -> busy high 3 cycles (T..T+2), low at T+3, data_in valid T+4. Reset asserted at T+1 during a store -> RAM word unchanged.
- Out of range: sw @BASE-4 and lw @BASE+4*2^ADDR_WIDTH -> RAM unchanged, load returns 0.
- Feature on: sh @BASE+1 -> store suppressed, misaligned=1 for one cycle. Feature off: same store writes lanes 0-1, misaligned stays 0.

Source files
------------

// File: rtl/riscv_data_memory.sv
// rtl/riscv_data_memory.sv - load/store data memory with wait states; optional RISCV_DMEM_MISALIGN_EN
module riscv_data_memory #(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic [1:0]  data_width,
  input  logic [31:0] data_out,
  input  logic        data_read,
  input  logic        data_write,
  output logic [31:0] data_in,
  output logic        busy,
  output logic        misaligned
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [31:0] ram [0:(1 << ADDR_WIDTH) - 1];

  state_t          state, state_next;
  logic [3:0]      cnt, cnt_next;
  logic            request, commit, in_range, bad;
  logic [31:0]     offset, load_word, load_data, store_data;
  logic [3:0]      lane_en;
  logic [ADDR_WIDTH-1:0] index;

  assign request  = data_read | data_write;
  assign offset   = data_address - BASE_ADDR;
  assign in_range = offset < (32'd4 << ADDR_WIDTH);
  assign index    = offset[ADDR_WIDTH+1:2];
  assign load_word = ram[index];

`ifdef RISCV_DMEM_MISALIGN_EN
  assign bad = ((data_width == 2'd1) && data_address[0]) ||
               ((data_width == 2'd2) && (data_address[1:0] != 2'b00)) ||
               (data_width == 2'd3);
`else
  assign bad = 1'b0;
`endif

  // State and wait counter register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state, stall output and commit decision
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy       = 1'b0;
    commit     = 1'b0;
    if (WAIT_STATES == 0) begin
      commit = request;
    end else begin
      case (state)
        S_IDLE: begin
          if (request) begin
            busy       = 1'b1;
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
        S_WAIT: begin
          if (!request) begin
            state_next = S_IDLE;
          end else if (cnt != 4'd0) begin
            busy     = 1'b1;
            cnt_next = cnt - 4'd1;
          end else begin
            commit     = 1'b1;
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Lane enables and replicated store data per access width
  always_comb begin
    lane_en    = 4'b1111;
    store_data = data_out;
    case (data_width)
      2'd0: begin
        lane_en    = 4'b0001 << data_address[1:0];
        store_data = {4{data_out[7:0]}};
      end
      2'd1: begin
        lane_en    = data_address[1] ? 4'b1100 : 4'b0011;
        store_data = {2{data_out[15:0]}};
      end
      default: begin
        lane_en    = 4'b1111;
        store_data = data_out;
      end
    endcase
  end

  // Right-aligned load data extraction
  always_comb begin
    load_data = load_word;
    case (data_width)
      2'd0:    load_data = {24'b0, load_word[{data_address[1:0], 3'b000} +: 8]};
      2'd1:    load_data = {16'b0, load_word[{data_address[1], 4'b0000} +: 16]};
      default: load_data = load_word;
    endcase
  end

  // Byte-lane RAM writes; contents survive reset
  always_ff @(posedge clock) begin
    if (reset && commit && data_write && in_range && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) ram[index][8*i +: 8] <= store_data[8*i +: 8];
      end
    end
  end

  // Load result register; a store (even with read high) leaves it untouched
  always_ff @(posedge clock) begin
    if (!reset) begin
      data_in <= 32'd0;
    end else if (commit && data_read && !data_write) begin
      data_in <= (in_range && !bad) ? load_data : 32'd0;
    end
  end

`ifdef RISCV_DMEM_MISALIGN_EN
  // One-cycle alignment-fault pulse following the commit
  always_ff @(posedge clock) begin
    if (!reset) misaligned <= 1'b0;
    else        misaligned <= commit && bad;
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule
